// File: rtl/roteamento_rr.sv
// M-channel to one registered output router, manual SEL or round-robin select.
// Optional per-channel accept counters behind ROTEAMENTO_CNT_EN.
module roteamento_rr #(
  parameter int N  = 4,
  parameter int M  = 4,
  parameter int SW = $clog2(M)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   SEL,
  output logic [N-1:0]    Saida,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   out_chan
`ifdef ROTEAMENTO_CNT_EN
  ,
  output logic [M*16-1:0] grant_count
`endif
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] gidx;
  logic          found;
  logic [M-1:0]  grant;
  logic          can_accept;
  logic          xfer;
  logic [N-1:0]  wdata;
  int            idx;

  assign can_accept = !out_valid || out_ready;

  // Round-robin scan starts just past the last RR winner
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    grant = '0;
    if (mode) begin
      for (int k = 1; k <= M; k++) begin
        idx = (int'(ptr) + k) % M;
        if (!found && in_valid[SW'(idx)]) begin
          found = 1'b1;
          gidx  = SW'(idx);
        end
      end
    end else if (int'(SEL) < M) begin
      if (in_valid[SEL]) begin
        found = 1'b1;
        gidx  = SEL;
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  assign in_ready = grant & {M{can_accept & rst_n}};
  assign xfer     = |(in_valid & in_ready);
  assign wdata    = in_data[int'(gidx)*N +: N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Saida     <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      ptr       <= SW'(M - 1);
    end else if (xfer) begin
      Saida     <= wdata;
      out_chan  <= gidx;
      out_valid <= 1'b1;
      if (mode) ptr <= gidx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ROTEAMENTO_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_count <= '0;
    end else if (xfer) begin
      for (int i = 0; i < M; i++) begin
        if (gidx == SW'(i) &&
            grant_count[i*16 +: 16] != 16'hFFFF)
          grant_count[i*16 +: 16] <=
            grant_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_roteamento_rr.sv
// Scoreboard bench for roteamento_rr: directed vectors,
// expected words queued by stimulus and popped by a monitor.
module tb_roteamento_rr;
  localparam int N  = 4;
  localparam int M  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [M*N-1:0]  in_data;
  logic [M-1:0]    in_valid;
  logic [M-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   SEL;
  logic [N-1:0]    Saida;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_chan;
`ifdef ROTEAMENTO_CNT_EN
  logic [M*16-1:0] grant_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [SW+N-1:0] exp_q[$];

  always #5 clk = ~clk;

  roteamento_rr #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .SEL(SEL),
    .Saida(Saida), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
`ifdef ROTEAMENTO_CNT_EN
    , .grant_count(grant_count)
`endif
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every word leaving the buffer must match the queue head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got ch%0d %h want none",
                 out_chan, Saida);
      end else begin
        chk("out_word", {54'd0, out_chan, Saida},
            {54'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input logic [3:0] v,
                     input logic ordy,
                     input logic [3:0] erdy,
                     input bit push,
                     input logic [3:0] ed,
                     input logic [1:0] ec);
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = ordy;
    #1;
    chk("in_ready", {60'd0, in_ready}, {60'd0, erdy});
    if (push) exp_q.push_back({ec, ed});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    mode      = 1'b1;
    SEL       = 2'd0;
    in_data   = 16'h4321;
    #3;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_saida", {60'd0, Saida}, 64'd0);
    chk("rst_chan", {62'd0, out_chan}, 64'd0);
    chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
    in_valid = 4'b0000;
    #9 rst_n = 1'b1;
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0);
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // manual mode, SEL=2
    mode    = 1'b0;
    SEL     = 2'd2;
    in_data = {4'h5, 4'hA, 4'h3, 4'h7};
    repeat (3) cyc(4'b1111, 1, 4'b0100, 1, 4'hA, 2'd2);
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0);

    // round-robin fairness, ptr untouched by manual mode
    mode    = 1'b1;
    in_data = 16'h4321;
    cyc(4'b1111, 1, 4'b0001, 1, 4'h1, 2'd0);
    cyc(4'b1111, 1, 4'b0010, 1, 4'h2, 2'd1);
    cyc(4'b1111, 1, 4'b0100, 1, 4'h3, 2'd2);
    cyc(4'b1111, 1, 4'b1000, 1, 4'h4, 2'd3);
    cyc(4'b1111, 1, 4'b0001, 1, 4'h1, 2'd0);
    cyc(4'b1111, 1, 4'b0010, 1, 4'h2, 2'd1);
    cyc(4'b1111, 1, 4'b0100, 1, 4'h3, 2'd2);
    cyc(4'b1111, 1, 4'b1000, 1, 4'h4, 2'd3);

    // skip and wrap after ch3
    cyc(4'b0101, 1, 4'b0001, 1, 4'h1, 2'd0);
    cyc(4'b0101, 1, 4'b0100, 1, 4'h3, 2'd2);
    cyc(4'b0101, 1, 4'b0001, 0, 0, 0);

    // backpressure: ch0 word (data 1) held
    repeat (3) begin
      cyc(4'b0101, 0, 4'b0000, 0, 0, 0);
      chk("bp_saida", {60'd0, Saida}, 64'h1);
      chk("bp_chan", {62'd0, out_chan}, 64'd0);
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
    end
    exp_q.push_back({2'd0, 4'h1});
    cyc(4'b0101, 1, 4'b0100, 1, 4'h3, 2'd2);
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0);
    chk("ovl_valid", {63'd0, out_valid}, 64'd1);
    chk("ovl_saida", {60'd0, Saida}, 64'h3);
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0);
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    chk("hold_saida", {60'd0, Saida}, 64'h3);
    chk("hold_chan", {62'd0, out_chan}, 64'd2);

    // async reset with a word in the buffer
    cyc(4'b1111, 0, 4'b1000, 0, 0, 0);
    @(posedge clk);
    #1 in_valid = 4'b0000;
    #1;
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("pre_rst_saida", {60'd0, Saida}, 64'h4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_saida", {60'd0, Saida}, 64'd0);
    chk("mid_rst_chan", {62'd0, out_chan}, 64'd0);
`ifdef ROTEAMENTO_CNT_EN
    chk("cnt_rst", grant_count, 64'd0);
`endif
    #1 rst_n = 1'b1;
    cyc(4'b1111, 1, 4'b0001, 1, 4'h1, 2'd0);
    cyc(4'b0011, 1, 4'b0010, 1, 4'h2, 2'd1);
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0);
`ifdef ROTEAMENTO_CNT_EN
    chk("cnt_after", grant_count,
        64'h0000_0000_0001_0001);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      @(posedge clk);
    #2;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
